// File: rtl/sobel_window_fetch.sv
// sobel_window_fetch
//
// Producer side of the Sobel pixel stream. It reads a stored grayscale frame
// from a synchronous-read frame RAM and replays it as a stream of 3x3 windows.
// Pixels within a window come out row-major. Windows are walked column-major,
// so the window row advances fast and the window column advances slowly.
// Window-last and frame-last markers travel with each pixel, so the consumer
// needs no position counters of its own.
//
// Each pixel takes three cycles: ISSUE (RAM read strobe), LOAD (capture the
// RAM data) and PRESENT (hold the pixel until the consumer accepts it).
//
// Optional build macro:
//   SOBEL_FETCH_ZERO_PAD_EN - one window centred on every pixel of the frame.
//                             Out-of-frame taps read as 0 and never touch the RAM.
//
// Ports:
//   clk_i            clock, rising edge
//   nreset_i         asynchronous active-low reset
//   start_i          begin one frame (sampled in IDLE only)
//   busy_o           frame in progress
//   done_o           one-cycle pulse after the last pixel transfer
//   mem_rd_o         frame RAM read strobe
//   mem_addr_o       frame RAM read address (0 while mem_rd_o is low)
//   mem_data_i       frame RAM read data, valid one cycle after mem_rd_o
//   px_o             output pixel
//   px_valid_o       px_o valid
//   px_ready_i       consumer accepts px_o
//   px_win_last_o    px_o is the 9th pixel of its window
//   px_frame_last_o  px_o is the final pixel of the frame

module sobel_window_fetch #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mem_rd_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [PIXEL_WIDTH-1:0] mem_data_i,
    output logic [PIXEL_WIDTH-1:0] px_o,
    output logic                   px_valid_o,
    input  logic                   px_ready_i,
    output logic                   px_win_last_o,
    output logic                   px_frame_last_o
);

    localparam int RW = $clog2(IMAGE_HEIGHT + 1);
    localparam int CW = $clog2(IMAGE_WIDTH + 1);

`ifdef SOBEL_FETCH_ZERO_PAD_EN
    // Window centres cover the whole frame; taps sit one row/column up-left.
    localparam int R_LAST = IMAGE_HEIGHT - 1;
    localparam int C_LAST = IMAGE_WIDTH - 1;
    localparam int OFS    = 1;
`else
    localparam int R_LAST = IMAGE_HEIGHT - 3;
    localparam int C_LAST = IMAGE_WIDTH - 3;
    localparam int OFS    = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_PRESENT,
        ST_FINISH
    } state_t;

    state_t                 state_q;
    logic [RW-1:0]          r_q, r_d;
    logic [CW-1:0]          c_q, c_d;
    logic [1:0]             dr_q, dr_d;
    logic [1:0]             dc_q, dc_d;
    logic                   busy_q;
    logic                   done_q;
    logic                   mem_rd_q;
    logic                   px_valid_q;
    logic                   win_last_q;
    logic                   frame_last_q;
    logic [PIXEL_WIDTH-1:0] px_q;

    logic                   win_last_w;
    logic                   frame_last_w;
    logic                   cur_in_frame;
    logic                   next_in_frame;
    logic [PIXEL_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0]  row_a;
    logic [ADDR_WIDTH-1:0]  col_a;
    logic [ADDR_WIDTH-1:0]  addr_w;

    // Counter values after one accepted pixel. dc is the fastest digit,
    // then dr, then the window row r, then the window column c.
    always_comb begin
        dc_d = dc_q;
        dr_d = dr_q;
        r_d  = r_q;
        c_d  = c_q;
        if (dc_q == 2'd2) begin
            dc_d = 2'd0;
            if (dr_q == 2'd2) begin
                dr_d = 2'd0;
                if (r_q == RW'(R_LAST)) begin
                    r_d = '0;
                    c_d = (c_q == CW'(C_LAST)) ? '0 : c_q + CW'(1);
                end else begin
                    r_d = r_q + RW'(1);
                end
            end else begin
                dr_d = dr_q + 2'd1;
            end
        end else begin
            dc_d = dc_q + 2'd1;
        end
    end

    assign win_last_w   = (dr_q == 2'd2) && (dc_q == 2'd2);
    assign frame_last_w = win_last_w && (r_q == RW'(R_LAST)) && (c_q == CW'(C_LAST));

    // Modular arithmetic in ADDR_WIDTH bits gives the same result as
    // computing the full linear address and truncating it.
    always_comb begin
        row_a  = ADDR_WIDTH'(r_q) + ADDR_WIDTH'(dr_q) - ADDR_WIDTH'(OFS);
        col_a  = ADDR_WIDTH'(c_q) + ADDR_WIDTH'(dc_q) - ADDR_WIDTH'(OFS);
        addr_w = row_a * ADDR_WIDTH'(IMAGE_WIDTH) + col_a;
    end

`ifdef SOBEL_FETCH_ZERO_PAD_EN
    function automatic logic in_frame(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                      input logic [1:0] dr, input logic [1:0] dc);
        int y;
        int x;
        y = int'(r) + int'(dr) - 1;
        x = int'(c) + int'(dc) - 1;
        return (y >= 0) && (y < IMAGE_HEIGHT) && (x >= 0) && (x < IMAGE_WIDTH);
    endfunction

    // Counters are stable through ISSUE and LOAD, so the current tap's
    // in-frame test can also pick between RAM data and the zero pad in LOAD.
    assign cur_in_frame  = in_frame(r_q, c_q, dr_q, dc_q);
    assign next_in_frame = in_frame(r_d, c_d, dr_d, dc_d);
    assign load_data     = cur_in_frame ? mem_data_i : '0;
`else
    assign cur_in_frame  = 1'b1;
    assign next_in_frame = 1'b1;
    assign load_data     = mem_data_i;
`endif

    // Main sequencer. mem_rd_q is set on entry to ISSUE, from the counters
    // that ISSUE will use, so the strobe is high for exactly the ISSUE cycle.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= ST_IDLE;
            r_q          <= '0;
            c_q          <= '0;
            dr_q         <= '0;
            dc_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
            px_valid_q   <= 1'b0;
            win_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            px_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q  <= ST_ISSUE;
                        busy_q   <= 1'b1;
                        mem_rd_q <= cur_in_frame;
                    end
                end
                ST_ISSUE: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= ST_LOAD;
                end
                ST_LOAD: begin
                    px_q         <= load_data;
                    px_valid_q   <= 1'b1;
                    win_last_q   <= win_last_w;
                    frame_last_q <= frame_last_w;
                    state_q      <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (px_valid_q && px_ready_i) begin
                        px_valid_q   <= 1'b0;
                        win_last_q   <= 1'b0;
                        frame_last_q <= 1'b0;
                        r_q          <= r_d;
                        c_q          <= c_d;
                        dr_q         <= dr_d;
                        dc_q         <= dc_d;
                        // done is raised here so it shows in the FINISH cycle,
                        // one cycle after the final transfer.
                        if (frame_last_q) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= ST_ISSUE;
                            mem_rd_q <= next_in_frame;
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    r_q     <= '0;
                    c_q     <= '0;
                    dr_q    <= '0;
                    dc_q    <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign mem_rd_o        = mem_rd_q;
    assign mem_addr_o      = mem_rd_q ? addr_w : '0;
    assign px_o            = px_q;
    assign px_valid_o      = px_valid_q;
    assign px_win_last_o   = win_last_q;
    assign px_frame_last_o = frame_last_q;

endmodule

// File: doc/sobel_window_fetch.md
Name: sobel_window_fetch

Overview:
- Producer side of the Sobel pixel stream.
- Reads a stored grayscale frame from a synchronous-read frame RAM.
- Emits pixels in 3x3 window order to the Sobel engine, one pixel per valid/ready transfer.
- Windows are walked column-major: row index fast, column index slow. Window-last and frame-last markers accompany the stream so the consumer needs no position counters of its own.

Parameters:
- PIXEL_WIDTH, 8, gray pixel width in bits.
- IMAGE_WIDTH, 8, frame columns (>=3).
- IMAGE_HEIGHT, 8, frame rows (>=3).
- ADDR_WIDTH, 6, frame RAM address width; must be >= clog2(IMAGE_WIDTH*IMAGE_HEIGHT).

Ports:
- clk_i  in  1  clock, rising edge.
- nreset_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin one frame; sampled in IDLE only.
- busy_o  out  1  high from the cycle after start is accepted until done.
- done_o  out  1  one-cycle pulse after the last pixel transfer.
- mem_rd_o  out  1  frame RAM read strobe.
- mem_addr_o  out  ADDR_WIDTH  read address, valid while mem_rd_o=1.
- mem_data_i  in  PIXEL_WIDTH  RAM read data, valid exactly 1 cycle after mem_rd_o.
- px_o  out  PIXEL_WIDTH  output pixel.
- px_valid_o  out  1  px_o valid.
- px_ready_i  in  1  consumer accepts px_o.
- px_win_last_o  out  1  qualifies px_o as 9th pixel of a window.
- px_frame_last_o  out  1  qualifies px_o as final pixel of the frame.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all counters 0. Takes effect immediately, including mid-frame. After release, only start_i restarts a frame; no partial stream resumes.
- Counters:
  - r: window top row, 0..IMAGE_HEIGHT-3.
  - c: window left column, 0..IMAGE_WIDTH-3.
  - k: in-window index 0..8, with dr=k/3 and dc=k%3 (held as separate 0..2 counters, no divider).
- Address: mem_addr_o = (r+dr)*IMAGE_WIDTH + (c+dc), truncated to ADDR_WIDTH. Computed from registered counters.
- In-window order is row-major: (r,c),(r,c+1),(r,c+2),(r+1,c)...(r+2,c+2).
- FSM states:
  - IDLE: start_i=1 -> ISSUE; busy_o<=1. Otherwise stay.
  - ISSUE: mem_rd_o=1 for exactly this cycle -> LOAD.
  - LOAD: px_o<=mem_data_i; px_valid_o<=1; win_last/frame_last registered from counters -> PRESENT.
  - PRESENT: hold px_o, px_valid_o and flags stable while px_ready_i=0. On px_valid_o&px_ready_i: px_valid_o<=0 and counters advance.
    - k<8: k+1.
    - k=8: k<=0 and r+1.
    - r wraps from IMAGE_HEIGHT-3 to 0 with c+1.
    - Next state: ISSUE, or FINISH if that was the frame-last pixel.
  - FINISH: done_o=1 for one cycle; busy_o<=0; counters cleared -> IDLE.
- Flag definitions:
  - px_win_last_o = (k==8).
  - px_frame_last_o = (k==8 & r==IMAGE_HEIGHT-3 & c==IMAGE_WIDTH-3).
- Rates and totals:
  - Throughput: one pixel per 3 cycles with px_ready_i tied high.
  - Pixels per frame: 9*(IMAGE_HEIGHT-2)*(IMAGE_WIDTH-2), which is 324 for 8x8.
- Edge rules:
  - start_i while busy is ignored.
  - px_ready_i outside PRESENT is ignored.
  - mem_rd_o is never asserted outside ISSUE.

Optional Feature:
- Macro: SOBEL_FETCH_ZERO_PAD_EN.
- Defined: one window centred on every pixel.
  - r in 0..IMAGE_HEIGHT-1, c in 0..IMAGE_WIDTH-1.
  - Pixel coordinates are (r-1+dr, c-1+dc).
  - Out-of-frame coordinates yield px_o=0. ISSUE still takes its cycle but mem_rd_o stays 0, and LOAD loads 0 instead of mem_data_i.
  - frame_last fires at r=IMAGE_HEIGHT-1, c=IMAGE_WIDTH-1.
  - 576 pixels per 8x8 frame.
- Undefined: valid-windows-only behaviour as above. No padding logic is synthesized.

Test Plan:
- Reset values: hold nreset_i=0 with start_i=1 -> all outputs 0, no mem_rd_o. Release, then pulse start_i -> mem_rd_o high with addr 0 two cycles later.
- Full frame, 8x8, RAM[a]=a, px_ready_i=1:
  - Window 0 yields 0,1,2,8,9,10,16,17,18, with win_last on 18.
  - Window 1 (r=1,c=0) starts 8,9,10.
  - The 324th pixel is 63 with frame_last=1.
  - done_o pulses once, 1 cycle after that transfer; busy_o drops with it.
- Backpressure: px_ready_i=0 for 5 cycles on pixel 4 (value 9) -> px_o=9 and px_valid_o stay stable, no new mem_rd_o. Release -> next pixel 10; total count still 324.
- Ignored start and mid-frame reset:
  - start_i pulsed during transfer 50 -> no restart; stream and count unchanged.
  - nreset_i low at transfer 100 -> outputs 0 immediately. A new start_i restarts from pixel value 0.
- With SOBEL_FETCH_ZERO_PAD_EN:
  - First window yields 0,0,0,0,0,1,0,8,9, with no mem_rd_o for the 5 padded positions.
  - The last window ends on a padded 0 with frame_last=1.
  - Total 576 transfers.
